ss_fifo: RTL and testbench
==========================

# ss_fifo

Parametrised synchronous FIFO for the ss streaming protocol: one ss slave port in, one ss master port out, buffering DEPTH words of data/keep/last/user. It sits between packet-processing stages to absorb backpressure. In PKT_MODE=1 it operates store-and-forward, presenting a packet only once its last word is buffered.

## Interface
- NUM_BYTES, 1, bytes per data word; data width is NUM_BYTES*8 and keep width is NUM_BYTES.
- USER_BITS, 1, width of user sideband.
- DEPTH, 16, words of storage; must be a power of two and at least 2.
- PKT_MODE, 0, 0 = cut-through, 1 = store-and-forward.
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  slave-side valid.
- s_ready  out  1  slave-side ready.
- s_data  in  NUM_BYTES*8  big-endian data.
- s_keep  in  NUM_BYTES  big-endian keep; meaningful on the last word.
- s_last  in  1  last word of packet.
- s_user  in  USER_BITS  sideband.
- m_valid  out  1  master-side valid.
- m_ready  in  1  master-side ready.
- m_data, m_keep, m_last, m_user  out  same widths as s_*  head-of-FIFO word.
- count  out  $clog2(DEPTH+1)  words stored.
- pkt_count  out  $clog2(DEPTH+1)  complete packets stored, i.e. stored words with last=1.

## Operation
- **Write:** a write occurs when s_valid && s_ready. The word {data, keep, last, user} is stored at wr_ptr, and wr_ptr increments.
- **Read:** a read occurs when m_valid && m_ready. rd_ptr increments.
- **Pointers:** $clog2(DEPTH) bits wide; they wrap DEPTH-1 -> 0 naturally.
- **count:** +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- **pkt_count:** +1 on a write with s_last=1, -1 on a read with m_last=1. Both in the same cycle leaves it unchanged.
- **s_ready:** s_ready = (count != DEPTH).
  - It is derived only from registered state, with no combinational path from m_ready.
  - When full, s_ready is low even if a read occurs in that cycle.
- **m_valid, cut-through:** m_valid = (count != 0).
- **m_valid, store-and-forward:** m_valid = (count != 0) && (pkt_count != 0 || count == DEPTH).
  - The full override is deadlock avoidance for packets longer than DEPTH. Such a packet then streams out cut-through.
- **m_\* outputs:** driven from storage at rd_ptr; they are don't-care when m_valid=0.
- **Pass-through:** keep, last and user are passed through unmodified. The block does not check keep on non-last words.
- **Master rules:** once m_valid is asserted, m_valid and m_* hold stable until the word is read. Nothing can invalidate a stored word, so the ss master rule is met by construction.
- **Reset (rst=0, asynchronous):**
  - wr_ptr, rd_ptr, count and pkt_count clear to 0.
  - Outputs go to s_ready=0, m_valid=0, count=0, pkt_count=0.
  - m_data, m_keep, m_last and m_user are 0; storage is not cleared, but outputs are masked to 0 while empty.
- **Reset mid-packet:** all buffered words, including partial packets, are discarded.
- **Release from reset:** s_ready rises on the first clk edge after rst deasserts.

## Timing
- **Latency:** a word written on edge N is visible on m_* with m_valid=1 after edge N, i.e. in cycle N+1.
  - In store-and-forward mode, m_valid rises the cycle after the last word of the packet is written.
- **Throughput:** one word per cycle sustained in both directions whenever 0 < count < DEPTH.
- **Empty:** simultaneous write while empty is allowed; m_valid rises the next cycle, so there is no bypass path.
- **Full:** simultaneous read while full accepts no write in that cycle. s_ready rises the following cycle.
- **Capacity:** all DEPTH entries are usable.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with s_valid=1 -> s_ready=0, m_valid=0, count=0, m_data=0. After release, s_ready=1 in the next cycle.
- **Cut-through streaming:** NUM_BYTES=4, DEPTH=4, PKT_MODE=0. Send a 3-word packet 0x00010203, 0x04050607, 0x08090000 with keep=4'b1100 on the last word and m_ready=1 -> the same words appear one cycle later with last only on word 3 and keep=4'b1100. count never exceeds 1.
- **Full and wrap:** m_ready=0, write 4 words -> count=4 and s_ready=0. Then pulse m_ready for 1 cycle -> one read and no write that cycle; s_ready=1 next cycle. Write 6 more words with random m_ready -> output order is preserved across pointer wrap.
- **Store-and-forward:** PKT_MODE=1, DEPTH=8. Write 3 words with last on word 3 -> m_valid=0 until the cycle after word 3 is written, then 3 words are read back and pkt_count returns to 0.
- **Oversize packet in store-and-forward:** PKT_MODE=1, DEPTH=4, 6-word packet with m_ready=1 -> m_valid rises when count=4. All 6 words are delivered in order and there is no deadlock.
- **Reset mid-packet:** assert rst after 2 of 3 words -> count=0 and m_valid=0. A new 1-word packet written afterwards is the first word out.

Source files
------------

// File: rtl/ss_fifo_if.sv
// ss streaming handshake bundle: valid/ready plus data, keep, last and user.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface ss_fifo_if #(
    parameter int NUM_BYTES = 1,
    parameter int USER_BITS = 1
) ();
    logic                   valid;
    logic                   ready;
    logic [NUM_BYTES*8-1:0] data;
    logic [NUM_BYTES-1:0]   keep;
    logic                   last;
    logic [USER_BITS-1:0]   user;

    modport master (
        output valid,
        output data,
        output keep,
        output last,
        output user,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  keep,
        input  last,
        input  user,
        output ready
    );
endinterface

// File: rtl/ss_fifo.sv
// ss_fifo: synchronous FIFO for the ss streaming protocol.
// Buffers DEPTH words of {data, keep, last, user}. In PKT_MODE=1 a word is only
// presented once a complete packet is buffered, or once the FIFO is full, so that
// packets longer than DEPTH cannot deadlock and stream out cut-through instead.
// Both ready and valid come from registered state only, so there is no
// combinational path from the input side to the output side, or back.
module ss_fifo #(
    parameter int NUM_BYTES = 1,
    parameter int USER_BITS = 1,
    parameter int DEPTH     = 16,
    parameter bit PKT_MODE  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    ss_fifo_if.slave                   s,
    ss_fifo_if.master                  m,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] pkt_count
);

    localparam int DW = NUM_BYTES * 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [DW-1:0]        data;
        logic [NUM_BYTES-1:0] keep;
        logic                 last;
        logic [USER_BITS-1:0] user;
    } word_t;

    // Storage is never reset; the empty mask keeps stale contents off the outputs.
    word_t         r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_pkt_count;
    // Low during reset and for the first edge after it, so s_ready stays low until then.
    logic          r_active;

    word_t w_in;
    word_t w_head;
    logic  w_empty;
    logic  w_full;
    logic  w_s_ready;
    logic  w_m_valid;
    logic  w_wr;
    logic  w_rd;
    logic  w_pkt_in;
    logic  w_pkt_out;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    // A full FIFO refuses writes even when a read is happening in the same cycle.
    assign w_s_ready = r_active && !w_full;

    if (PKT_MODE) begin : g_store_fwd
        // Present only complete packets; a full FIFO overrides this to avoid deadlock.
        assign w_m_valid = !w_empty && ((r_pkt_count != '0) || w_full);
    end else begin : g_cut_thru
        assign w_m_valid = !w_empty;
    end

    assign w_wr      = s.valid && w_s_ready;
    assign w_rd      = w_m_valid && m.ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_pkt_in  = w_wr && s.last;
    assign w_pkt_out = w_rd && w_head.last;

    assign w_in.data = s.data;
    assign w_in.keep = s.keep;
    assign w_in.last = s.last;
    assign w_in.user = s.user;

    assign s.ready   = w_s_ready;
    assign m.valid   = w_m_valid;
    assign m.data    = w_empty ? '0   : w_head.data;
    assign m.keep    = w_empty ? '0   : w_head.keep;
    assign m.last    = w_empty ? 1'b0 : w_head.last;
    assign m.user    = w_empty ? '0   : w_head.user;
    assign count     = r_count;
    assign pkt_count = r_pkt_count;

    // Store the accepted input word at the write pointer.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Word occupancy: a simultaneous read and write leave it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Complete-packet occupancy: counts stored words that carry last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pkt_count <= '0;
        end else begin
            case ({w_pkt_in, w_pkt_out})
                2'b10:   r_pkt_count <= r_pkt_count + CW'(1);
                2'b01:   r_pkt_count <= r_pkt_count - CW'(1);
                default: r_pkt_count <= r_pkt_count;
            endcase
        end
    end

    // Enable the input side on the first edge after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ss_fifo.sv
// Testbench for ss_fifo. Three instances share clk and rst:
//   unit 0: DEPTH=4, cut-through
//   unit 1: DEPTH=8, store-and-forward
//   unit 2: DEPTH=4, store-and-forward (oversize packet case)
// Accepted input words are pushed to a per-unit scoreboard queue and popped and
// compared when the unit is expected to deliver a word. A small occupancy model
// supplies the expected s_ready, m_valid, count and pkt_count every cycle.
module tb_ss_fifo;

    localparam int NU = 3;

    logic clk;
    logic rst;

    logic        sv [NU];
    logic [31:0] sd [NU];
    logic [3:0]  sk [NU];
    logic        sl [NU];
    logic [1:0]  su [NU];
    logic        mr [NU];

    logic        sr [NU];
    logic        mv [NU];
    logic [31:0] md [NU];
    logic [3:0]  mk [NU];
    logic        ml [NU];
    logic [1:0]  mu [NU];
    logic [3:0]  cnt [NU];
    logic [3:0]  pcnt [NU];

    int          n_vec;
    int          n_miss;

    int          m_cnt [NU];
    int          m_pkt [NU];
    bit          m_act [NU];
    bit          acc [NU];
    logic [38:0] sb [NU][$];
    int          max_cnt0;

    for (genvar gi = 0; gi < NU; gi++) begin : g_dut
        localparam int DEP = (gi == 1) ? 8 : 4;
        localparam bit PM  = (gi != 0);
        localparam int CW  = $clog2(DEP + 1);

        ss_fifo_if #(.NUM_BYTES(4), .USER_BITS(2)) s_if ();
        ss_fifo_if #(.NUM_BYTES(4), .USER_BITS(2)) m_if ();
        logic [CW-1:0] w_cnt;
        logic [CW-1:0] w_pcnt;

        assign s_if.valid = sv[gi];
        assign s_if.data  = sd[gi];
        assign s_if.keep  = sk[gi];
        assign s_if.last  = sl[gi];
        assign s_if.user  = su[gi];
        assign m_if.ready = mr[gi];
        assign sr[gi]     = s_if.ready;
        assign mv[gi]     = m_if.valid;
        assign md[gi]     = m_if.data;
        assign mk[gi]     = m_if.keep;
        assign ml[gi]     = m_if.last;
        assign mu[gi]     = m_if.user;
        assign cnt[gi]    = 4'(w_cnt);
        assign pcnt[gi]   = 4'(w_pcnt);

        ss_fifo #(
            .NUM_BYTES(4),
            .USER_BITS(2),
            .DEPTH    (DEP),
            .PKT_MODE (PM)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .s        (s_if),
            .m        (m_if),
            .count    (w_cnt),
            .pkt_count(w_pcnt)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle: compare at the falling edge, update the model, then move
    // to just after the next rising edge where the caller drives new inputs.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NU; i++) begin
            int          d;
            bit          pm;
            bit          er;
            bit          ev;
            bit          wr;
            bit          rd;
            logic [38:0] e;
            d  = (i == 1) ? 8 : 4;
            pm = (i != 0);
            er = m_act[i] && (m_cnt[i] != d);
            ev = (m_cnt[i] != 0) && (!pm || m_pkt[i] != 0 || m_cnt[i] == d);
            check($sformatf("u%0d s_ready", i), 64'(sr[i]), 64'(er));
            check($sformatf("u%0d m_valid", i), 64'(mv[i]), 64'(ev));
            check($sformatf("u%0d count", i), 64'(cnt[i]), 64'(m_cnt[i]));
            check($sformatf("u%0d pkt_count", i), 64'(pcnt[i]), 64'(m_pkt[i]));
            if (m_cnt[i] == 0) begin
                check($sformatf("u%0d m_data_empty", i), 64'(md[i]), 64'(0));
            end
            if (i == 0 && int'(cnt[0]) > max_cnt0) max_cnt0 = int'(cnt[0]);
            wr = er && sv[i];
            rd = ev && mr[i];
            if (rd) begin
                e = sb[i].pop_front();
                check($sformatf("u%0d m_word", i), 64'({md[i], mk[i], ml[i], mu[i]}), 64'(e));
                if (e[2]) m_pkt[i]--;
            end
            if (wr) begin
                sb[i].push_back({sd[i], sk[i], sl[i], su[i]});
                if (sl[i]) m_pkt[i]++;
            end
            m_cnt[i] = m_cnt[i] + int'(wr) - int'(rd);
            acc[i] = wr;
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NU; i++) m_act[i] = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        for (int i = 0; i < NU; i++) begin
            m_cnt[i] = 0;
            m_pkt[i] = 0;
            m_act[i] = 1'b0;
            sb[i].delete();
        end
        for (int c = 0; c < cycles; c++) step();
        rst = 1'b1;
    endtask

    task automatic idle();
        for (int i = 0; i < NU; i++) begin
            sv[i] = 1'b0;
            sl[i] = 1'b0;
        end
    endtask

    task automatic drive(input int u, input logic [31:0] d, input logic [3:0] k,
                         input logic l, input logic [1:0] us);
        sv[u] = 1'b1;
        sd[u] = d;
        sk[u] = k;
        sl[u] = l;
        su[u] = us;
    endtask

    task automatic drain(input int u);
        int guard;
        sv[u] = 1'b0;
        mr[u] = 1'b1;
        guard = 0;
        while (m_cnt[u] != 0 && guard < 40) begin
            step();
            guard++;
        end
        check($sformatf("u%0d drain_done", u), 64'(m_cnt[u]), 64'(0));
    endtask

    // Keep offering words to unit u until n have been accepted (bounded).
    task automatic send_pkt(input int u, input int n, input logic [31:0] base, input bit rand_ready);
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        while (sent < n && guard < 100) begin
            drive(u, base + 32'(sent), 4'hF, (sent == n - 1), 2'(sent));
            if (rand_ready) mr[u] = 1'($urandom_range(0, 1));
            step();
            if (acc[u]) sent++;
            guard++;
        end
        check($sformatf("u%0d send_done", u), 64'(sent), 64'(n));
        sv[u] = 1'b0;
        sl[u] = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        max_cnt0 = 0;
        rst      = 1'b1;
        for (int i = 0; i < NU; i++) begin
            sv[i] = 1'b0; sd[i] = '0; sk[i] = '0; sl[i] = 1'b0; su[i] = '0; mr[i] = 1'b0;
        end
        #2;

        // Reset held three cycles with s_valid high: nothing accepted, outputs zero.
        for (int i = 0; i < NU; i++) drive(i, 32'hDEAD_BEEF, 4'hF, 1'b1, 2'h3);
        do_reset(3);
        idle();
        step();   // release cycle: s_ready still low
        step();   // s_ready now high in the model and the DUT

        // Cut-through streaming on unit 0.
        mr[0] = 1'b1;
        max_cnt0 = 0;
        drive(0, 32'h0001_0203, 4'hF, 1'b0, 2'h1); step();
        drive(0, 32'h0405_0607, 4'hF, 1'b0, 2'h2); step();
        drive(0, 32'h0809_0000, 4'hC, 1'b1, 2'h3); step();
        idle();
        drain(0);
        check("u0 ct_max_count", 64'(max_cnt0), 64'(1));

        // Fill unit 0, one read while full, then wrap with random m_ready.
        mr[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 32'hF000_0000 + 32'(k), 4'hF, (k == 3), 2'(k));
            step();
        end
        check("u0 full_count", 64'(cnt[0]), 64'(4));
        check("u0 full_s_ready", 64'(sr[0]), 64'(0));
        drive(0, 32'hF000_0010, 4'hF, 1'b0, 2'h0);
        mr[0] = 1'b1;
        step();   // read while full, write refused
        mr[0] = 1'b0;
        sv[0] = 1'b0;
        step();   // s_ready back high
        send_pkt(0, 6, 32'hA000_0000, 1'b1);
        drain(0);

        // Store-and-forward on unit 1: nothing presented until the last word lands.
        mr[1] = 1'b1;
        send_pkt(1, 3, 32'hB000_0000, 1'b0);
        drain(1);

        // Oversize 6-word packet on unit 2 (DEPTH=4) streams out once full.
        mr[2] = 1'b1;
        send_pkt(2, 6, 32'hC000_0000, 1'b0);
        drain(2);

        // Reset mid-packet on unit 0, then a fresh 1-word packet comes out first.
        mr[0] = 1'b0;
        drive(0, 32'hD000_0000, 4'hF, 1'b0, 2'h0); step();
        drive(0, 32'hD000_0001, 4'hF, 1'b0, 2'h1); step();
        idle();
        do_reset(1);
        check("u0 rst_mid_count", 64'(cnt[0]), 64'(0));
        check("u0 rst_mid_m_valid", 64'(mv[0]), 64'(0));
        step();
        mr[0] = 1'b1;
        drive(0, 32'hE000_0055, 4'h8, 1'b1, 2'h2);
        step();
        idle();
        check("u0 new_pkt_first", 64'(md[0]), 64'(32'hE000_0055));
        drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
